// File: rtl/alu_operand_stage_if.sv
// Purpose : bundles the decoded-op input, ALU operand output and write-back
//           buses of the operand-fetch stage.
// Latency : n/a (signal container only).
// Backpr. : in_valid/in_ready on the op input, out_valid/out_ready on the ALU
//           side; write-back is a plain strobe with no backpressure.
// Ports   : master = op producer / ALU consumer / write-back source,
//           slave  = alu_operand_stage.
interface alu_operand_stage_if #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  parameter int CTRL_W = 4
);
  localparam int AW = $clog2(NREG);

  // decoded op from the issue side
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctr;
  logic [AW-1:0]     in_ra;
  logic [AW-1:0]     in_rb;
  logic              in_imm_en;
  logic [DATA_W-1:0] in_imm;
  logic [AW-1:0]     in_rd;

  // registered operands towards the ALU
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] SrcA;
  logic [DATA_W-1:0] SrcB;
  logic [CTRL_W-1:0] ALUCtr;
  logic [AW-1:0]     out_rd;

  // ALU result returning to the register file
  logic              wb_en;
  logic [AW-1:0]     wb_rd;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output in_valid, in_ctr, in_ra, in_rb, in_imm_en, in_imm, in_rd,
    output out_ready,
    output wb_en, wb_rd, wb_data,
    input  in_ready,
    input  out_valid, SrcA, SrcB, ALUCtr, out_rd
  );

  modport slave (
    input  in_valid, in_ctr, in_ra, in_rb, in_imm_en, in_imm, in_rd,
    input  out_ready,
    input  wb_en, wb_rd, wb_data,
    output in_ready,
    output out_valid, SrcA, SrcB, ALUCtr, out_rd
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Purpose : operand fetch in front of the 8-bit ALU: register file read with
//           write-back bypass, scoreboard hazard stall, registered operands.
// Latency : 1 cycle from op accept to out_valid; write-back lands in 1 cycle.
// Backpr. : single output slot; in_ready drops while the slot is held
//           (out_valid & !out_ready) or the op touches a pending register.
// Ports   : clk, rst_n (async, active low); bus = alu_operand_stage_if.slave
//           (in_* op input, out_valid/out_ready + SrcA/SrcB/ALUCtr/out_rd
//           output, wb_en/wb_rd/wb_data write-back).
module alu_operand_stage #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  parameter int CTRL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_operand_stage_if.slave bus
);

  localparam int AW = $clog2(NREG);

  typedef struct packed {
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [CTRL_W-1:0] ctr;
    logic [AW-1:0]     rd;
  } op_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_rf [NREG];  // entry 0 is never written, reads forced to 0
  logic [NREG-1:0]   r_sb;         // 1 = result for this register still in flight
  logic              r_out_vld;
  op_t               r_out;

  // ---------------------------------------------------------------------------
  // Combinational
  // ---------------------------------------------------------------------------
  logic [NREG-1:0]   w_wb_clr;     // scoreboard bit released by this cycle's write-back
  logic [NREG-1:0]   w_iss_set;    // scoreboard bit claimed by this cycle's accept
  logic [NREG-1:0]   w_pend;       // scoreboard as seen by the hazard check
  logic              w_hazard;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_consume;
  logic              w_wb_wr;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  op_t               w_op;

  assign w_wb_wr = bus.wb_en && (bus.wb_rd != '0);

  always_comb begin
    w_wb_clr = '0;
    if (w_wb_wr) begin
      w_wb_clr[bus.wb_rd] = 1'b1;
    end
  end

  // A write-back arriving this cycle already resolves its register, so the
  // op waiting on it can issue in the same cycle and pick the value off the
  // bypass below.
  assign w_pend = r_sb & ~w_wb_clr;

  assign w_hazard = w_pend[bus.in_ra]
                  | (!bus.in_imm_en && w_pend[bus.in_rb])
                  | w_pend[bus.in_rd];

  assign w_slot_free  = !r_out_vld || bus.out_ready;
  assign bus.in_ready = w_slot_free && !w_hazard;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_consume    = r_out_vld && bus.out_ready;

  // Register read with write-back bypass. r0 is hard-wired to zero and is
  // applied last so a write-back addressed to r0 can never leak through.
  always_comb begin
    w_rd_a = r_rf[bus.in_ra];
    if (w_wb_wr && (bus.wb_rd == bus.in_ra)) begin
      w_rd_a = bus.wb_data;
    end
    if (bus.in_ra == '0) begin
      w_rd_a = '0;
    end

    w_rd_b = r_rf[bus.in_rb];
    if (w_wb_wr && (bus.wb_rd == bus.in_rb)) begin
      w_rd_b = bus.wb_data;
    end
    if (bus.in_rb == '0) begin
      w_rd_b = '0;
    end
  end

  always_comb begin
    w_op       = '0;
    w_op.src_a = w_rd_a;
    w_op.src_b = bus.in_imm_en ? bus.in_imm : w_rd_b;
    w_op.ctr   = bus.in_ctr;
    w_op.rd    = bus.in_rd;
  end

  always_comb begin
    w_iss_set = '0;
    if (w_accept && (bus.in_rd != '0)) begin
      w_iss_set[bus.in_rd] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output slot: loads on accept, empties on consume; data holds otherwise so
  // the ALU sees bit-stable operands while it stalls us.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_out     <= '0;
    end else if (w_accept) begin
      r_out_vld <= 1'b1;
      r_out     <= w_op;
    end else if (w_consume) begin
      r_out_vld <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. A write-back to a register that is not pending is still
  // committed; the scoreboard only gates issue, never writes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_wb_wr) begin
      r_rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard. Set is applied after clear so a new producer for a register
  // wins over the write-back of the previous one on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb <= '0;
    end else begin
      r_sb <= (r_sb & ~w_wb_clr) | w_iss_set;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.out_valid = r_out_vld;
  assign bus.SrcA      = r_out.src_a;
  assign bus.SrcB      = r_out.src_b;
  assign bus.ALUCtr    = r_out.ctr;
  assign bus.out_rd    = r_out.rd;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (r_out_vld && !bus.out_ready) |=> (r_out_vld && $stable(r_out)));

  a_r0_never_pending : assert property (@(posedge clk) disable iff (!rst_n)
    !r_sb[0]);

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;
  localparam int DATA_W = 8;
  localparam int NREG   = 8;
  localparam int CTRL_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_operand_stage_if #(.DATA_W(DATA_W), .NREG(NREG), .CTRL_W(CTRL_W)) bus ();

  alu_operand_stage #(.DATA_W(DATA_W), .NREG(NREG), .CTRL_W(CTRL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural register values, pending flags and the
  // single in-flight op as seen by the ALU.
  logic [7:0] m_rf   [8];
  logic       m_pend [8];
  logic       m_vld;
  logic [7:0] m_a, m_b;
  logic [3:0] m_ctr;
  logic [2:0] m_rd;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_rf[i]   = 8'h00;
      m_pend[i] = 1'b0;
    end
    m_vld = 1'b0; m_a = 8'h00; m_b = 8'h00; m_ctr = 4'h0; m_rd = 3'd0;
  endtask

  // Value an op would see for register r this cycle.
  function automatic logic [7:0] m_read(input logic [2:0] r);
    if (r == 3'd0) return 8'h00;
    if (bus.wb_en && bus.wb_rd == r) return bus.wb_data;
    return m_rf[r];
  endfunction

  // Register r still awaits a result that is not arriving this cycle.
  function automatic logic m_busy(input logic [2:0] r);
    return (r != 3'd0) && m_pend[r] && !(bus.wb_en && bus.wb_rd == r);
  endfunction

  function automatic logic m_ready();
    logic room;
    room = !m_vld || bus.out_ready;
    return room && !m_busy(bus.in_ra) && !(!bus.in_imm_en && m_busy(bus.in_rb))
           && !m_busy(bus.in_rd);
  endfunction

  function automatic logic [23:0] dut_vec();
    return {bus.out_valid, bus.SrcA, bus.SrcB, bus.ALUCtr, bus.out_rd};
  endfunction

  function automatic logic [23:0] model_vec();
    return {m_vld, m_a, m_b, m_ctr, m_rd};
  endfunction

  task automatic drive_op(input logic v, input logic [3:0] ctr, input logic [2:0] ra,
                          input logic [2:0] rb, input logic ie, input logic [7:0] imm,
                          input logic [2:0] rd);
    bus.in_valid = v; bus.in_ctr = ctr; bus.in_ra = ra; bus.in_rb = rb;
    bus.in_imm_en = ie; bus.in_imm = imm; bus.in_rd = rd;
  endtask

  task automatic drive_wb(input logic en, input logic [2:0] rd, input logic [7:0] d);
    bus.wb_en = en; bus.wb_rd = rd; bus.wb_data = d;
  endtask

  task automatic idle();
    drive_op(1'b0, 4'h0, 3'd0, 3'd0, 1'b0, 8'h00, 3'd0);
    drive_wb(1'b0, 3'd0, 8'h00);
  endtask

  // One clock: samples in_ready mid-cycle, advances the model on the edge,
  // returns 1 time unit after the edge with the inputs still applied.
  task automatic cycle(output logic obs_rdy, output logic exp_rdy);
    logic acc;
    @(negedge clk);
    obs_rdy = bus.in_ready;
    exp_rdy = m_ready();
    @(posedge clk);
    acc = bus.in_valid && exp_rdy;
    if (acc) begin
      m_a   = m_read(bus.in_ra);
      m_b   = bus.in_imm_en ? bus.in_imm : m_read(bus.in_rb);
      m_ctr = bus.in_ctr;
      m_rd  = bus.in_rd;
      m_vld = 1'b1;
    end else if (m_vld && bus.out_ready) begin
      m_vld = 1'b0;
    end
    if (bus.wb_en && bus.wb_rd != 3'd0) begin
      m_rf[bus.wb_rd]   = bus.wb_data;
      m_pend[bus.wb_rd] = 1'b0;
    end
    if (acc && bus.in_rd != 3'd0) m_pend[bus.in_rd] = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic o, e;
    idle();
    bus.out_ready = 1'b0;
    m_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== 24'h0) begin
      n_bad++; $display("FAIL reset_initial: got %h want %h", dut_vec(), 24'h0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // build up an in-flight op with pend[3] set, then reset under it
    drive_wb(1'b1, 3'd1, 8'hAA);
    cycle(o, e);
    drive_wb(1'b0, 3'd0, 8'h00);
    drive_op(1'b1, 4'h5, 3'd1, 3'd2, 1'b0, 8'h00, 3'd3);
    cycle(o, e);
    n_cmp++;
    if (dut_vec() !== {1'b1, 8'hAA, 8'h00, 4'h5, 3'd3}) begin
      n_bad++; $display("FAIL reset_prestate: got %h want %h", dut_vec(), {1'b1, 8'hAA, 8'h00, 4'h5, 3'd3});
    end
    idle();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== 24'h0) begin
      n_bad++; $display("FAIL reset_midstream: got %h want %h", dut_vec(), 24'h0);
    end
    m_reset();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // pend[3] must be gone: an op touching r3 is not stalled
    bus.out_ready = 1'b1;
    drive_op(1'b0, 4'h0, 3'd3, 3'd3, 1'b0, 8'h00, 3'd3);
    cycle(o, e);
    n_cmp++;
    if (o !== 1'b1) begin
      n_bad++; $display("FAIL reset_pend_clear: in_ready %b want 1", o);
    end
    for (int i = 1; i < 8; i++) begin
      drive_op(1'b1, 4'h0, 3'(i), 3'(i), 1'b0, 8'h00, 3'd0);
      cycle(o, e);
      n_cmp++;
      if (dut_vec() !== {1'b1, 8'h00, 8'h00, 4'h0, 3'd0}) begin
        n_bad++; $display("FAIL reset_rf_r%0d: got %h want %h", i, dut_vec(), {1'b1, 8'h00, 8'h00, 4'h0, 3'd0});
      end
    end
    idle();
    cycle(o, e);
  endtask

  task automatic test_wb_issue();
    logic o, e;
    bus.out_ready = 1'b1;
    drive_wb(1'b1, 3'd1, 8'hF0); cycle(o, e);
    drive_wb(1'b1, 3'd2, 8'h05); cycle(o, e);
    drive_wb(1'b0, 3'd0, 8'h00);
    drive_op(1'b1, 4'h1, 3'd1, 3'd2, 1'b0, 8'h00, 3'd3);
    cycle(o, e);
    idle();
    n_cmp++;
    if (dut_vec() !== {1'b1, 8'hF0, 8'h05, 4'h1, 3'd3}) begin
      n_bad++; $display("FAIL wb_issue: got %h want %h", dut_vec(), {1'b1, 8'hF0, 8'h05, 4'h1, 3'd3});
    end
  endtask

  task automatic test_raw_stall();
    logic o, e;
    bus.out_ready = 1'b1;
    drive_op(1'b1, 4'h2, 3'd3, 3'd0, 1'b0, 8'h00, 3'd5);
    for (int k = 0; k < 3; k++) begin
      cycle(o, e);
      n_cmp++;
      if (o !== 1'b0) begin
        n_bad++; $display("FAIL raw_stall_%0d: in_ready %b want 0", k, o);
      end
    end
    drive_wb(1'b1, 3'd3, 8'hF5);
    cycle(o, e);
    n_cmp++;
    if (o !== 1'b1) begin
      n_bad++; $display("FAIL raw_release: in_ready %b want 1", o);
    end
    idle();
    n_cmp++;
    if (dut_vec() !== {1'b1, 8'hF5, 8'h00, 4'h2, 3'd5}) begin
      n_bad++; $display("FAIL raw_bypass: got %h want %h", dut_vec(), {1'b1, 8'hF5, 8'h00, 4'h2, 3'd5});
    end
    drive_wb(1'b1, 3'd5, 8'h11); cycle(o, e);
    idle();
  endtask

  task automatic test_hold_b2b();
    logic o, e;
    bus.out_ready = 1'b0;
    drive_op(1'b1, 4'h7, 3'd1, 3'd2, 1'b0, 8'h00, 3'd6);
    cycle(o, e);
    drive_op(1'b1, 4'h3, 3'd1, 3'd1, 1'b0, 8'h00, 3'd1);
    for (int k = 0; k < 5; k++) begin
      cycle(o, e);
      n_cmp++;
      if (o !== 1'b0) begin
        n_bad++; $display("FAIL hold_ready_%0d: in_ready %b want 0", k, o);
      end
      n_cmp++;
      if (dut_vec() !== {1'b1, 8'hF0, 8'h05, 4'h7, 3'd6}) begin
        n_bad++; $display("FAIL hold_stable_%0d: got %h want %h", k, dut_vec(), {1'b1, 8'hF0, 8'h05, 4'h7, 3'd6});
      end
    end
    bus.out_ready = 1'b1;
    drive_op(1'b1, 4'h9, 3'd2, 3'd1, 1'b0, 8'h00, 3'd7);
    cycle(o, e);
    n_cmp++;
    if (o !== 1'b1) begin
      n_bad++; $display("FAIL b2b_ready: in_ready %b want 1", o);
    end
    n_cmp++;
    if (dut_vec() !== {1'b1, 8'h05, 8'hF0, 4'h9, 3'd7}) begin
      n_bad++; $display("FAIL b2b_issue: got %h want %h", dut_vec(), {1'b1, 8'h05, 8'hF0, 4'h9, 3'd7});
    end
    idle();
    drive_wb(1'b1, 3'd6, 8'h66); cycle(o, e);
    drive_wb(1'b1, 3'd7, 8'h77); cycle(o, e);
    idle();
  endtask

  task automatic test_imm_r0();
    logic o, e;
    bus.out_ready = 1'b1;
    drive_op(1'b1, 4'h0, 3'd0, 3'd0, 1'b0, 8'h00, 3'd3);
    cycle(o, e);
    drive_op(1'b1, 4'h4, 3'd0, 3'd3, 1'b1, 8'h0A, 3'd2);
    cycle(o, e);
    n_cmp++;
    if (o !== 1'b1) begin
      n_bad++; $display("FAIL imm_no_stall: in_ready %b want 1", o);
    end
    n_cmp++;
    if (dut_vec() !== {1'b1, 8'h00, 8'h0A, 4'h4, 3'd2}) begin
      n_bad++; $display("FAIL imm_operand: got %h want %h", dut_vec(), {1'b1, 8'h00, 8'h0A, 4'h4, 3'd2});
    end
    drive_op(1'b1, 4'h6, 3'd0, 3'd0, 1'b0, 8'h00, 3'd0);
    drive_wb(1'b1, 3'd0, 8'hFF);
    cycle(o, e);
    n_cmp++;
    if (dut_vec() !== {1'b1, 8'h00, 8'h00, 4'h6, 3'd0}) begin
      n_bad++; $display("FAIL r0_no_bypass: got %h want %h", dut_vec(), {1'b1, 8'h00, 8'h00, 4'h6, 3'd0});
    end
    drive_wb(1'b0, 3'd0, 8'h00);
    drive_op(1'b1, 4'h8, 3'd0, 3'd0, 1'b0, 8'h00, 3'd0);
    cycle(o, e);
    n_cmp++;
    if (dut_vec() !== {1'b1, 8'h00, 8'h00, 4'h8, 3'd0}) begin
      n_bad++; $display("FAIL r0_write_dropped: got %h want %h", dut_vec(), {1'b1, 8'h00, 8'h00, 4'h8, 3'd0});
    end
    idle();
    drive_wb(1'b1, 3'd3, 8'h33); cycle(o, e);
    drive_wb(1'b1, 3'd2, 8'h22); cycle(o, e);
    idle();
  endtask

  task automatic test_waw_same_edge();
    logic o, e;
    bus.out_ready = 1'b1;
    drive_op(1'b1, 4'h2, 3'd1, 3'd1, 1'b0, 8'h00, 3'd4);
    drive_wb(1'b1, 3'd4, 8'h44);
    cycle(o, e);
    n_cmp++;
    if (o !== 1'b1) begin
      n_bad++; $display("FAIL waw_accept: in_ready %b want 1", o);
    end
    drive_wb(1'b0, 3'd0, 8'h00);
    drive_op(1'b1, 4'h3, 3'd4, 3'd0, 1'b1, 8'h00, 3'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(o, e);
      n_cmp++;
      if (o !== 1'b0) begin
        n_bad++; $display("FAIL waw_set_wins_%0d: in_ready %b want 0", k, o);
      end
    end
    drive_wb(1'b1, 3'd4, 8'h99);
    cycle(o, e);
    idle();
    n_cmp++;
    if (dut_vec() !== {1'b1, 8'h99, 8'h00, 4'h3, 3'd0}) begin
      n_bad++; $display("FAIL waw_release: got %h want %h", dut_vec(), {1'b1, 8'h99, 8'h00, 4'h3, 3'd0});
    end
  endtask

  task automatic test_random();
    logic o, e;
    for (int n = 0; n < 600; n++) begin
      drive_op($urandom_range(0, 3) != 0, 4'($urandom), 3'($urandom), 3'($urandom),
               $urandom_range(0, 2) == 0, 8'($urandom), 3'($urandom));
      if ($urandom_range(0, 9) < 4) drive_wb(1'b1, 3'($urandom), 8'($urandom));
      else                          drive_wb(1'b0, 3'd0, 8'h00);
      bus.out_ready = $urandom_range(0, 3) != 0;
      cycle(o, e);
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL rnd_ready cycle %0d: in_ready %b want %b", n, o, e);
      end
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL rnd_out cycle %0d: got %h want %h", n, dut_vec(), model_vec());
      end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wb_issue();
    test_raw_stall();
    test_hold_b2b();
    test_imm_r0();
    test_waw_same_edge();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
